// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall signal bundle between the pipeline datapath and the hazard stall controller.
// The master side is the pipeline and the slave side is the controller.
interface hazard_stall_controller_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] ifIdRs;
   logic [REG_W-1:0] ifIdRt;
   logic             idExMemRead;
   logic [REG_W-1:0] idExRt;
   logic             mdStart;
   logic             mdUsesResult;
   logic             exMemAccess;
   logic             memReady;
   logic             branchTaken;

   logic             pcWrite;
   logic             ifIdWrite;
   logic             ifIdFlush;
   logic             idExBubble;
   logic             freeze;
   logic             mdBusy;
   logic [CNT_W-1:0] stallCycles;

   modport master (
      output ifIdRs, ifIdRt, idExMemRead, idExRt, mdStart, mdUsesResult,
             exMemAccess, memReady, branchTaken,
      input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, freeze, mdBusy, stallCycles
   );

   modport slave (
      input  ifIdRs, ifIdRt, idExMemRead, idExRt, mdStart, mdUsesResult,
             exMemAccess, memReady, branchTaken,
      output pcWrite, ifIdWrite, ifIdFlush, idExBubble, freeze, mdBusy, stallCycles
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage MIPS core: resolves load-use, mult/div occupancy,
// data-memory wait and taken-branch hazards, and counts stall cycles.
module hazard_stall_controller #(
   parameter int REG_W      = 5,
   parameter int MD_LATENCY = 8,
   parameter int CNT_W      = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   hazard_stall_controller_if.slave hz
);

   localparam int MD_W = $clog2(MD_LATENCY + 1);

   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_RUN     = 2'd1,
      ST_LDSTALL = 2'd2,
      ST_MEMWAIT = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic mem_wait;
   logic md_hazard;
   logic load_use;
   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_bubble;
   logic freeze_o;

   // Hazard detection terms, evaluated in the same cycle they take effect.
   always_comb begin
      mem_wait  = hz.exMemAccess && !hz.memReady;
      md_hazard = (hz.mdUsesResult || hz.mdStart) && (md_cnt_q != '0);
      load_use  = (state_q == ST_RUN) && hz.idExMemRead && (hz.idExRt != '0) &&
                  ((hz.idExRt == hz.ifIdRs) || (hz.idExRt == hz.ifIdRt));
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      freeze_o     = 1'b0;
      if (state_q == ST_RESET) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (mem_wait) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         freeze_o     = 1'b1;
      end else if (hz.branchTaken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (md_hazard || load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   always_comb begin
      state_d = ST_RUN;
      if (state_q == ST_RESET) begin
         state_d = ST_RUN;
      end else if (mem_wait) begin
         state_d = ST_MEMWAIT;
      end else if (!hz.branchTaken && !md_hazard && load_use) begin
         state_d = ST_LDSTALL;
      end
   end

   // The mult/div unit keeps counting through a freeze; a flushed or stalled mdStart never issues.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (hz.mdStart && (md_cnt_q == '0) && pc_write && !if_id_flush) begin
         md_cnt_d = MD_W'(MD_LATENCY);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q != ST_RESET) && !pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.pcWrite     = pc_write;
   assign hz.ifIdWrite   = if_id_write;
   assign hz.ifIdFlush   = if_id_flush;
   assign hz.idExBubble  = id_ex_bubble;
   assign hz.freeze      = freeze_o;
   assign hz.mdBusy      = (md_cnt_q != '0);
   assign hz.stallCycles = stall_cnt_q;

`ifndef SYNTHESIS
   a_freeze_holds: assert property (@(posedge clk) disable iff (!rst_n)
      hz.freeze |-> (!hz.pcWrite && !hz.idExBubble && !hz.ifIdFlush));
   a_md_bounded: assert property (@(posedge clk) disable iff (!rst_n)
      md_cnt_q <= MD_W'(MD_LATENCY));
   a_flush_loads_pc: assert property (@(posedge clk) disable iff (!rst_n)
      (hz.ifIdFlush && state_q != ST_RESET) |-> hz.pcWrite);
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: a driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_stall_controller;

   localparam int REG_W     = 5;
   localparam int MD_LAT    = 8;
   localparam int CNT_W     = 4;
   localparam int STALL_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [REG_W-1:0] ifIdRs;
      logic [REG_W-1:0] ifIdRt;
      logic [REG_W-1:0] idExRt;
      logic             idExMemRead;
      logic             mdStart;
      logic             mdUsesResult;
      logic             exMemAccess;
      logic             memReady;
      logic             branchTaken;
   } stim_t;

   typedef struct {
      logic pc;
      logic ifw;
      logic flush;
      logic bub;
      logic frz;
      logic busy;
      int   stall;
   } exp_t;

   logic clk;
   logic rst_n;
   int   assertions_evaluated = 0;
   int   failures = 0;
   exp_t scoreboard[$];

   int md_left;
   int stall_count;
   bit in_startup;
   bit last_load_stall;
   bit last_mem_wait;

   hazard_stall_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

   hazard_stall_controller #(
      .REG_W(REG_W),
      .MD_LATENCY(MD_LAT),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .hz(hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertions_evaluated++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
      end
   endtask

   // Monitor: every cycle the DUT presents its outputs; compare against the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         checkOutput("pcWrite",     32'(hz.pcWrite),     32'(e.pc));
         checkOutput("ifIdWrite",   32'(hz.ifIdWrite),   32'(e.ifw));
         checkOutput("ifIdFlush",   32'(hz.ifIdFlush),   32'(e.flush));
         checkOutput("idExBubble",  32'(hz.idExBubble),  32'(e.bub));
         checkOutput("freeze",      32'(hz.freeze),      32'(e.frz));
         checkOutput("mdBusy",      32'(hz.mdBusy),      32'(e.busy));
         checkOutput("stallCycles", 32'(hz.stallCycles), 32'(e.stall));
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.memReady = 1'b1;
      return s;
   endfunction

   // Drives one cycle (called just after a rising edge), records the expected response,
   // advances the reference model, then returns just after the next rising edge.
   task automatic applyStimulus(input stim_t s, input logic rst_val);
      exp_t e;
      bit   mem_wait, md_haz, ld_use;
      hz.ifIdRs       = s.ifIdRs;
      hz.ifIdRt       = s.ifIdRt;
      hz.idExRt       = s.idExRt;
      hz.idExMemRead  = s.idExMemRead;
      hz.mdStart      = s.mdStart;
      hz.mdUsesResult = s.mdUsesResult;
      hz.exMemAccess  = s.exMemAccess;
      hz.memReady     = s.memReady;
      hz.branchTaken  = s.branchTaken;
      rst_n           = rst_val;

      if (!rst_val) begin
         md_left         = 0;
         stall_count     = 0;
         in_startup      = 1'b1;
         last_load_stall = 1'b0;
         last_mem_wait   = 1'b0;
      end

      mem_wait = s.exMemAccess && !s.memReady;
      md_haz   = (s.mdUsesResult || s.mdStart) && (md_left > 0);
      ld_use   = !last_load_stall && !last_mem_wait && s.idExMemRead && (s.idExRt != 0) &&
                 ((s.idExRt == s.ifIdRs) || (s.idExRt == s.ifIdRt));

      e.busy  = (md_left > 0);
      e.stall = stall_count;
      e.frz   = 1'b0;
      e.flush = 1'b0;
      e.bub   = 1'b0;
      e.pc    = 1'b1;
      e.ifw   = 1'b1;
      if (in_startup) begin
         e.pc = 1'b0; e.ifw = 1'b0; e.flush = 1'b1; e.bub = 1'b1;
      end else if (mem_wait) begin
         e.pc = 1'b0; e.ifw = 1'b0; e.frz = 1'b1;
      end else if (s.branchTaken) begin
         e.flush = 1'b1; e.bub = 1'b1;
      end else if (md_haz || ld_use) begin
         e.pc = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
      end
      scoreboard.push_back(e);

      if (rst_val) begin
         if (!in_startup && !e.pc) stall_count = (stall_count < STALL_MAX) ? stall_count + 1 : STALL_MAX;
         if (s.mdStart && md_left == 0 && e.pc && !e.flush) md_left = MD_LAT;
         else if (md_left > 0) md_left = md_left - 1;
         last_mem_wait   = !in_startup && mem_wait;
         last_load_stall = !in_startup && !mem_wait && !s.branchTaken && !md_haz && ld_use;
         in_startup      = 1'b0;
      end

      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(idle(), 1'b0);
   endtask

   initial begin : driver
      stim_t s;
      rst_n = 1'b0;
      s = idle();
      hz.ifIdRs = s.ifIdRs; hz.ifIdRt = s.ifIdRt; hz.idExRt = s.idExRt;
      hz.idExMemRead = 1'b0; hz.mdStart = 1'b0; hz.mdUsesResult = 1'b0;
      hz.exMemAccess = 1'b0; hz.memReady = 1'b1; hz.branchTaken = 1'b0;
      md_left = 0; stall_count = 0; in_startup = 1'b1;
      last_load_stall = 1'b0; last_mem_wait = 1'b0;
      @(posedge clk);
      #1;

      // Reset and startup bubble
      doReset(3);
      for (int i = 0; i < 3; i++) applyStimulus(idle(), 1'b1);

      // Load-use with a real register, then with $zero
      s = idle(); s.idExMemRead = 1'b1; s.idExRt = 5'd8; s.ifIdRs = 5'd8;
      applyStimulus(s, 1'b1);
      applyStimulus(s, 1'b1);
      applyStimulus(idle(), 1'b1);
      s.idExRt = 5'd0; s.ifIdRs = 5'd0;
      applyStimulus(s, 1'b1);
      s = idle(); s.idExMemRead = 1'b1; s.idExRt = 5'd9; s.ifIdRt = 5'd9;
      applyStimulus(s, 1'b1);
      applyStimulus(idle(), 1'b1);

      // Mult/div issue followed by mflo three cycles later
      s = idle(); s.mdStart = 1'b1;
      applyStimulus(s, 1'b1);
      applyStimulus(idle(), 1'b1);
      applyStimulus(idle(), 1'b1);
      s = idle(); s.mdUsesResult = 1'b1;
      for (int i = 0; i < 7; i++) applyStimulus(s, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(idle(), 1'b1);

      // Memory wait for four cycles
      s = idle(); s.exMemAccess = 1'b1; s.memReady = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(s, 1'b1);
      s.memReady = 1'b1;
      applyStimulus(s, 1'b1);
      applyStimulus(idle(), 1'b1);

      // Branch versus load-use, then memory wait versus branch
      s = idle(); s.branchTaken = 1'b1; s.idExMemRead = 1'b1; s.idExRt = 5'd4; s.ifIdRs = 5'd4;
      applyStimulus(s, 1'b1);
      applyStimulus(idle(), 1'b1);
      s = idle(); s.branchTaken = 1'b1; s.exMemAccess = 1'b1; s.memReady = 1'b0;
      applyStimulus(s, 1'b1);
      s.memReady = 1'b1;
      applyStimulus(s, 1'b1);
      applyStimulus(idle(), 1'b1);

      // Saturation after 20 stalled cycles
      doReset(1);
      applyStimulus(idle(), 1'b1);
      s = idle(); s.exMemAccess = 1'b1; s.memReady = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus(s, 1'b1);
      applyStimulus(idle(), 1'b1);

      // Abort mid mult/div
      s = idle(); s.mdStart = 1'b1;
      applyStimulus(s, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(idle(), 1'b1);
      doReset(2);
      applyStimulus(idle(), 1'b1);

      // Randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(99) < 2) begin
            doReset(1 + $urandom_range(1));
         end else begin
            s.idExMemRead  = ($urandom_range(99) < 35);
            s.idExRt       = 5'($urandom_range(3));
            s.ifIdRs       = 5'($urandom_range(3));
            s.ifIdRt       = 5'($urandom_range(3));
            s.mdStart      = ($urandom_range(99) < 15);
            s.mdUsesResult = ($urandom_range(99) < 15);
            s.exMemAccess  = ($urandom_range(99) < 40);
            s.memReady     = ($urandom_range(99) < 65);
            s.branchTaken  = ($urandom_range(99) < 10);
            applyStimulus(s, 1'b1);
         end
      end

      for (int i = 0; i < 5 && scoreboard.size() > 0; i++) @(negedge clk);
      #1;
      if (scoreboard.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
      $finish;
   end

endmodule
